// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: digit/scan-control inputs and the
// registered anode/segment drive back to the board pins.
interface seg_scan_ctrl_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output en, digits, dp, blink_mask,
        input  an, seg, dp_n, digit_idx, frame_tick
    );

    modport slave (
        input  en, digits, dp, blink_mask,
        output an, seg, dp_n, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with guard blanking and
// frame-coherent digit snapshot. Define SEG_BLINK_EN for per-digit blinking.
module seg_scan_ctrl #(
    parameter int DWELL     = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 128
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam int CMAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_digits_q, snap_digits_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_tick_q, frame_tick_d;
    logic          frame_end;
    logic          lit;

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
`else
    logic unused_blink;
    assign unused_blink = ^{bus.blink_mask, BLINK_DIV[0]};
`endif

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        frame_end     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d       = ST_GUARD;
                    cnt_d         = '0;
                    idx_d         = 2'd0;
                    snap_digits_d = bus.digits;
                    snap_dp_d     = bus.dp;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    // The snapshot only changes between frames so a digit never tears.
                    if (idx_q == 2'd3) begin
                        frame_end     = 1'b1;
                        snap_digits_d = bus.digits;
                        snap_dp_d     = bus.dp;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
        endcase

        if (!bus.en) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            idx_d         = 2'd0;
            frame_end     = 1'b0;
            snap_digits_d = snap_digits_q;
            snap_dp_d     = snap_dp_q;
        end

        frame_tick_d = frame_end;
        lit          = (state_d == ST_SHOW);

`ifdef SEG_BLINK_EN
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_end) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
        if (phase_d && bus.blink_mask[idx_d]) begin
            lit = 1'b0;
        end
`endif

        an_d   = lit ? ~(4'b0001 << idx_d) : 4'hF;
        seg_d  = lit ? decode(snap_digits_d[idx_d*4 +: 4]) : 7'h7F;
        dp_n_d = lit ? ~snap_dp_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the alarm clock's 4-digit common-anode 7-segment display. Sequences a 2-bit digit index 0→1→2→3→0 with a fixed dwell per digit and an anti-ghosting blank interval between digits. Drives anode selects and decoded segment lines from a frame-coherent snapshot of four BCD digits, with optional per-digit blinking for alarm-set mode. Sits between the timekeeping/alarm logic and the board display pins.

## Interface
- DWELL, 50000, clk cycles a digit is lit per visit (≥1)
- GUARD, 16, clk cycles all digits are blanked before each digit is lit (≥1)
- BLINK_DIV, 128, scan frames per blink half-period (≥1; used only with SEG_BLINK_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  scan enable; low forces the display dark and idle
- digits  in  16  four BCD nibbles; digit 0 = [3:0], digit 3 = [15:12]
- dp  in  4  decimal point per digit, active-high
- blink_mask  in  4  per-digit blink request, active-high
- an  out  4  anode selects, active-low, one-hot-low or all high
- seg  out  7  segments a..g, active-low, seg[0]=a … seg[6]=g
- dp_n  out  1  decimal point, active-low
- digit_idx  out  2  index of the digit being guarded/shown
- frame_tick  out  1  one-cycle pulse when a full 4-digit frame completes

## Operation
- States: IDLE, GUARD, SHOW. Reset: IDLE, digit_idx=0, cycle counter=0, an=4'b1111, seg=7'h7F, dp_n=1, frame_tick=0, snapshot=0, blink phase=0, frame counter=0.
- IDLE: outputs dark. en=1 → GUARD, counter=0, digit_idx=0, snapshot loaded.
- GUARD: an=4'b1111, seg=7'h7F, dp_n=1 for GUARD cycles, then → SHOW, counter=0.
- SHOW: an[digit_idx]=0, others 1; seg = decode(snapshot nibble[digit_idx]); dp_n = ~snapshot_dp[digit_idx]. After DWELL cycles → GUARD with digit_idx+1 (2-bit wrap 3→0).
- Leaving SHOW with digit_idx=3: frame_tick=1 for that one cycle; snapshot of digits and dp reloaded on the same edge (display never tears mid-frame).
- Decode: 0–9 standard patterns (0=7'h40, 1=7'h79, 8=7'h00); BCD 10–15 → blank (7'h7F).
- en=0 in any state: next edge → IDLE, digit_idx=0, counter=0, outputs dark, no frame_tick. Blink phase and frame counter hold.
- rst low in any state overrides en, returns to the reset values on the next edge.

## Timing
- All outputs registered; an/seg/dp_n/digit_idx change on the same edge as the state.
- en sampled high at edge k (from IDLE): GUARD in cycles k..k+GUARD-1; first an=4'b1110 at edge k+GUARD.
- Digit period GUARD+DWELL cycles; frame period 4·(GUARD+DWELL) cycles; frame_tick every frame period in steady state.
- digits/dp changes mid-frame become visible only from the next frame's digit 0.
- Never more than one an bit low; at least GUARD dark cycles between any two lit digits.

## Configuration
- SEG_BLINK_EN defined: frame counter counts frame_ticks; at BLINK_DIV ticks it clears and blink phase toggles. While phase=1 and blink_mask[digit_idx]=1, SHOW keeps an=4'b1111 (digit dark, timing unchanged). blink_mask sampled live, not snapshotted.
- SEG_BLINK_EN undefined: no frame counter or phase register; blink_mask ignored; all digits always lit in SHOW.

## Test plan
- DWELL=4, GUARD=2; reset low 3 cycles, then en=1, digits=16'h1234 → an=1111 for 2 cycles, 1110 with seg=7'h19 (4) for 4 cycles, 2 dark, 1101 seg=7'h30 (3); frame_tick every 24 cycles.
- Change digits to 16'h5678 while digit_idx=1 → digits 2,3 still show 2,1; new values appear from next frame's digit 0.
- digits=16'hFA90, dp=4'b0010 → digit 2 and 3 blank (7'h7F), digit 1 shows 9 with dp_n=0, digit 0 shows 0 with dp_n=1.
- en=0 during SHOW of digit 2 → next edge an=1111, digit_idx=0, no frame_tick; en=1 again → restart at GUARD of digit 0.
- rst low mid-GUARD with en=1 → next edge all outputs at reset values, state IDLE; one-hot-low an checked every cycle.
- SEG_BLINK_EN, BLINK_DIV=2, blink_mask=4'b0001 → digit 0 dark in frames 3–4, lit in 1–2 and 5–6; other digits always lit; undefined build keeps digit 0 lit in all frames.
